// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, stall buffering,
// redirect flush. Optional misaligned-PC trap under FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc_current,
  output logic [31:0] add_pc_out,
  fetch_unit_if.master mem,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] hold_instr;
  logic        trap;
  logic        handshake;

  assign pc_current = pc_q;
  assign add_pc_out = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned PC parks the fetch in REQ without requesting until redirected.
  assign trap           = (state == S_REQ) && (pc_q[1:0] != 2'b00);
  assign mem.imem_addr  = pc_q;
  assign fetch_misalign = trap;
`else
  assign trap           = 1'b0;
  assign mem.imem_addr  = {pc_q[31:2], 2'b00};
  assign fetch_misalign = 1'b0;
`endif

  assign mem.imem_req = (state == S_REQ) && !trap;
  assign handshake    = mem.imem_req && mem.imem_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc_q        <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_instr <= 32'h0;
      hold_instr  <= 32'h0;
    end else begin
      // Default: bubble when ID can accept; overridden by a delivery below.
      if (!stall) if_id_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (trap) if_id_valid <= 1'b0;
          if (redirect) begin
            pc_q        <= pc_next;
            if_id_valid <= 1'b0;
            if (handshake) state <= S_DRAIN;
          end else if (handshake) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_q        <= pc_next;
            if_id_valid <= 1'b0;
            state       <= mem.imem_rvalid ? S_REQ : S_DRAIN;
          end else if (mem.imem_rvalid) begin
            if (!stall) begin
              if_id_valid <= 1'b1;
              if_id_pc    <= pc_q;
              if_id_instr <= mem.imem_rdata;
              pc_q        <= pc_next;
              state       <= S_REQ;
            end else begin
              hold_instr <= mem.imem_rdata;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_q        <= pc_next;
            if_id_valid <= 1'b0;
            hold_instr  <= 32'h0;
            state       <= S_REQ;
          end else if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc_q;
            if_id_instr <= hold_instr;
            pc_q        <= pc_next;
            state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          // The stale response is swallowed; redirects here only move the PC.
          if (redirect) begin
            pc_q        <= pc_next;
            if_id_valid <= 1'b0;
          end
          if (mem.imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
